bram_regfile_mt: RTL and testbench

- Multithreaded RISC-V integer register file built from block/distributed RAM.
- Holds NUM_THREADS x 32 registers; one write port and two read ports (rs1, rs2), each read port backed by its own simple-dual-port RAM copy.
- Sits between decode (read) and writeback (write) of the barrel pipeline.
- Enforces x0 == 0, clears itself after reset via a sequential clear engine, and optionally forwards same-cycle writes to reads.

---
 rtl/bram_regfile_mt.sv | 153 +++++++++++++++
 tb/tb_bram_regfile_mt.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_regfile_mt.sv
// Multithreaded RISC-V integer register file: two RAM copies (rs1, rs2) sharing one write port.
// Clears itself after reset; define REGFILE_BYPASS_EN to forward same-cycle writes to colliding reads.
module bram_regfile_mt #(
    parameter int NUM_THREADS         = 16,
    parameter int DATA_WIDTH          = 32,
    parameter int ENABLE_BRAM_REGFILE = 1,
    localparam int TID_WIDTH          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [TID_WIDTH-1:0]  wr_tid,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [TID_WIDTH-1:0]  rd_tid,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  init_done
);
    localparam int DEPTH   = NUM_THREADS * 32;
    localparam int DEPTH_W = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                  zero1_q, zero1_d, zero2_q, zero2_d;
    logic                  ram_we;
    logic [DEPTH_W-1:0]    ram_waddr, rd1_idx, rd2_idx;
    logic [DATA_WIDTH-1:0] ram_wdata, ram1_rdata, ram2_rdata;

    assign rd1_idx = DEPTH_W'({rd_tid, rs1_addr});
    assign rd2_idx = DEPTH_W'({rd_tid, rs2_addr});

    // The clear engine owns the write port until every entry has been zeroed.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_waddr = DEPTH_W'({wr_tid, wr_addr});
        ram_wdata = wr_data;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + DEPTH_W'(1);
                if (clr_cnt_q == DEPTH_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ram_we = wr_en && (wr_addr != 5'd0);
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // x0 and reads issued during clear are masked at the output, independent of RAM contents.
    always_comb begin
        zero1_d = zero1_q;
        zero2_d = zero2_q;
        if (rd_en) begin
            zero1_d = (state_q == ST_CLEAR) || (rs1_addr == 5'd0);
            zero2_d = (state_q == ST_CLEAR) || (rs2_addr == 5'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            zero1_q   <= 1'b1;
            zero2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            zero1_q   <= zero1_d;
            zero2_q   <= zero2_d;
        end
    end

    assign init_done = (state_q == ST_READY);

    if (ENABLE_BRAM_REGFILE != 0) begin : g_bram
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem1 [DEPTH];
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem2 [DEPTH];
        always_ff @(posedge clk) begin
            if (ram_we) begin
                mem1[ram_waddr] <= ram_wdata;
                mem2[ram_waddr] <= ram_wdata;
            end
            if (rd_en) begin
                ram1_rdata <= mem1[rd1_idx];
                ram2_rdata <= mem2[rd2_idx];
            end
        end
    end else begin : g_dram
        (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem1 [DEPTH];
        (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem2 [DEPTH];
        always_ff @(posedge clk) begin
            if (ram_we) begin
                mem1[ram_waddr] <= ram_wdata;
                mem2[ram_waddr] <= ram_wdata;
            end
            if (rd_en) begin
                ram1_rdata <= mem1[rd1_idx];
                ram2_rdata <= mem2[rd2_idx];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic                  wr_hit;
    logic                  byp1_q, byp1_d, byp2_q, byp2_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

    // Collision compare is captured with the read so the outputs stay purely registered.
    always_comb begin
        wr_hit     = wr_en && (state_q == ST_READY) && (wr_tid == rd_tid) && (wr_addr != 5'd0);
        byp1_d     = byp1_q;
        byp2_d     = byp2_q;
        byp_data_d = byp_data_q;
        if (rd_en) begin
            byp1_d     = wr_hit && (wr_addr == rs1_addr);
            byp2_d     = wr_hit && (wr_addr == rs2_addr);
            byp_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign rs1_data = zero1_q ? '0 : (byp1_q ? byp_data_q : ram1_rdata);
    assign rs2_data = zero2_q ? '0 : (byp2_q ? byp_data_q : ram2_rdata);
`else
    assign rs1_data = zero1_q ? '0 : ram1_rdata;
    assign rs2_data = zero2_q ? '0 : ram2_rdata;
`endif

endmodule

// File: tb/tb_bram_regfile_mt.sv
// Bench for bram_regfile_mt (4 threads): random traffic against an array model of the register file,
// plus directed clear-timing, x0, isolation, collision, hold and reset-during-clear cases.
module tb_bram_regfile_mt;
    localparam int NT    = 4;
    localparam int DW    = 32;
    localparam int TW    = 2;
    localparam int DEPTH = NT * 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [TW-1:0] wr_tid = '0;
    logic [4:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [TW-1:0] rd_tid = '0;
    logic [4:0]    rs1_addr = '0;
    logic [4:0]    rs2_addr = '0;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          init_done;

    always #5 clk = ~clk;

    bram_regfile_mt #(
        .NUM_THREADS(NT),
        .DATA_WIDTH(DW),
        .ENABLE_BRAM_REGFILE(1)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_tid(wr_tid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_tid(rd_tid),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .init_done(init_done)
    );

    // Reference model: register contents per thread, current output values, clear progress.
    logic [DW-1:0] m_mem [NT][32];
    logic [DW-1:0] m_rs1, m_rs2;
    int            m_clr_cycles;
    logic [DW-1:0] exp_q [$];
    int            checks;
    int            failures;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [TW-1:0] tid, input logic [4:0] a,
                                                 input bit ready);
        if (!ready || a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_tid == tid && wr_addr == a) return wr_data;
`endif
        return m_mem[tid][a];
    endfunction

    task automatic model_reset();
        foreach (m_mem[t, r]) m_mem[t][r] = '0;
        m_rs1        = '0;
        m_rs2        = '0;
        m_clr_cycles = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic we, input logic [TW-1:0] wt, input logic [4:0] wa,
                         input logic [DW-1:0] wd, input logic re, input logic [TW-1:0] rt,
                         input logic [4:0] a1, input logic [4:0] a2);
        wr_en    = we;
        wr_tid   = wt;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en    = re;
        rd_tid   = rt;
        rs1_addr = a1;
        rs2_addr = a2;
    endtask

    // One clock edge: update the model from the inputs now applied, then compare after the edge.
    task automatic do_cycle(input string tag);
        bit            ready;
        logic [DW-1:0] e1, e2;
        ready = (m_clr_cycles >= DEPTH);
        if (rd_en) begin
            m_rs1 = model_read(rd_tid, rs1_addr, ready);
            m_rs2 = model_read(rd_tid, rs2_addr, ready);
        end
        if (ready && wr_en && wr_addr != 5'd0) m_mem[wr_tid][wr_addr] = wr_data;
        if (!ready) m_clr_cycles++;
        exp_q.push_back(m_rs1);
        exp_q.push_back(m_rs2);
        @(posedge clk);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        check({tag, "_rs1"}, rs1_data, e1);
        check({tag, "_rs2"}, rs2_data, e2);
        check({tag, "_init"}, DW'(init_done), DW'(m_clr_cycles >= DEPTH));
    endtask

    task automatic rand_cycle(input string tag);
        logic [TW-1:0] wt, rt;
        logic [4:0]    wa, a1, a2;
        wt = TW'($urandom_range(0, NT - 1));
        rt = ($urandom_range(0, 1) == 1) ? wt : TW'($urandom_range(0, NT - 1));
        wa = 5'($urandom_range(0, 5));
        a1 = 5'($urandom_range(0, 5));
        a2 = 5'($urandom_range(0, 5));
        drive(1'($urandom_range(0, 1)), wt, wa, $urandom, 1'($urandom_range(0, 1)), rt, a1, a2);
        do_cycle(tag);
    endtask

    task automatic do_reset(input string tag, input int hold);
        reset = 1'b1;
        #1;
        check({tag, "_async_rs1"}, rs1_data, '0);
        check({tag, "_async_rs2"}, rs2_data, '0);
        check({tag, "_async_init"}, DW'(init_done), '0);
        model_reset();
        repeat (hold) @(posedge clk);
        #1;
        check({tag, "_hold_rs1"}, rs1_data, '0);
        check({tag, "_hold_init"}, DW'(init_done), '0);
        reset = 1'b0;
    endtask

    // Random traffic through the clear window; init_done must rise exactly DEPTH edges after release.
    task automatic run_clear(input string tag);
        int rise_at;
        rise_at = -1;
        for (int c = 1; c <= DEPTH + 20 && rise_at < 0; c++) begin
            rand_cycle(tag);
            if (init_done) rise_at = c;
        end
        check({tag, "_latency"}, DW'(rise_at), DW'(DEPTH));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rs1", rs1_data, '0);
        check("reset_rs2", rs2_data, '0);
        check("reset_init", DW'(init_done), '0);
        reset = 1'b0;
        run_clear("clr1");

        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd3, 5'd31, 5'd31);
        do_cycle("t3x31");
        check("t3x31_lit", rs1_data, 32'h0);

        drive(1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 5'd0, 5'd0);
        do_cycle("wr_t1x5");
        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd1, 5'd5, 5'd5);
        do_cycle("rd_t1x5");
        check("rd_t1x5_lit1", rs1_data, 32'hDEADBEEF);
        check("rd_t1x5_lit2", rs2_data, 32'hDEADBEEF);
        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd2, 5'd5, 5'd5);
        do_cycle("rd_t2x5");
        check("rd_t2x5_lit", rs1_data, 32'h0);

        drive(1'b1, 2'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 2'd0, 5'd0, 5'd0);
        do_cycle("wr_x0");
        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd0, 5'd0, 5'd0);
        do_cycle("rd_x0");
        check("rd_x0_lit", rs1_data, 32'h0);

        drive(1'b1, 2'd2, 5'd7, 32'hA5A5A5A5, 1'b0, 2'd0, 5'd0, 5'd0);
        do_cycle("pre_coll");
        drive(1'b1, 2'd2, 5'd7, 32'h12345678, 1'b1, 2'd2, 5'd7, 5'd0);
        do_cycle("coll");
`ifdef REGFILE_BYPASS_EN
        check("coll_lit", rs1_data, 32'h12345678);
`else
        check("coll_lit", rs1_data, 32'hA5A5A5A5);
`endif
        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd2, 5'd7, 5'd7);
        do_cycle("post_coll");
        check("post_coll_lit", rs1_data, 32'h12345678);

        drive(1'b1, 2'd0, 5'd3, 32'h11, 1'b0, 2'd0, 5'd0, 5'd0);
        do_cycle("wr_x3");
        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd0, 5'd3, 5'd0);
        do_cycle("rd_x3");
        drive(1'b0, 2'd0, 5'd0, '0, 1'b0, 2'd0, 5'd4, 5'd0);
        do_cycle("hold");
        check("hold_lit", rs1_data, 32'h11);

        for (int i = 0; i < 500; i++) rand_cycle("rand1");

        drive(1'b1, 2'd1, 5'd9, 32'hCAFEF00D, 1'b0, 2'd0, 5'd0, 5'd0);
        do_cycle("wr_t1x9");
        drive(1'b0, 2'd0, 5'd0, '0, 1'b1, 2'd1, 5'd9, 5'd9);
        do_cycle("rd_t1x9");
        check("rd_t1x9_lit", rs1_data, 32'hCAFEF00D);
        do_reset("rst_ready", 2);

        for (int c = 0; c < 40; c++) begin
            drive(1'(c % 2), 2'd1, 5'd9, $urandom, 1'b1, 2'd1, 5'd9, 5'd9);
            do_cycle("clr2");
        end
        do_reset("rst_mid", 3);
        run_clear("clr3");
        drive(1'b1, 2'd0, 5'd1, $urandom, 1'b1, 2'd1, 5'd9, 5'd9);
        do_cycle("rd_t1x9_cleared");
        check("rd_t1x9_cleared_lit", rs2_data, 32'h0);

        for (int i = 0; i < 200; i++) rand_cycle("rand2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
